// File: rtl/parking_keypad_entry_pkg.sv
// Shared types and 7-segment constants for the parking gate keypad front end.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONE  = 2'd1,
      TWO  = 2'd2,
      SEND = 2'd3
   } state_t;

   typedef logic [1:0] digit_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/parking_keypad_entry_if.sv
// Keypad-in / password-out bundle; master is the entry block, slave is the keypad plus gate side.
interface parking_keypad_entry_if;
   import parking_pkg::*;

   logic       key_strobe;
   digit_t     key_code;
   logic       key_enter;
   logic       key_clear;
   logic       pw_ack;
   logic       pw_valid;
   digit_t     password_1;
   digit_t     password_2;
   logic [1:0] digit_count;
   logic       timeout_flag;
   logic [6:0] HEX_1;
   logic [6:0] HEX_2;

   modport master (
      input  key_strobe, key_code, key_enter, key_clear, pw_ack,
      output pw_valid, password_1, password_2, digit_count, timeout_flag, HEX_1, HEX_2
   );

   modport slave (
      output key_strobe, key_code, key_enter, key_clear, pw_ack,
      input  pw_valid, password_1, password_2, digit_count, timeout_flag, HEX_1, HEX_2
   );

endinterface

// File: rtl/parking_keypad_entry_seg7_digit_decoder.sv
// Combinational 2-bit digit to active-low 7-segment pattern; blank when absent, dash when masked.
module seg7_digit_decoder
   import parking_pkg::*;
(
   input  digit_t     digit,
   input  logic       present,
   input  logic       mask,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (present) begin
         if (mask) begin
            seg = SEG_DASH;
         end else begin
            case (digit)
               2'd0:    seg = SEG_0;
               2'd1:    seg = SEG_1;
               2'd2:    seg = SEG_2;
               default: seg = SEG_3;
            endcase
         end
      end
   end

endmodule

// File: rtl/parking_keypad_entry.sv
// Two-digit keypad entry with valid/ack password hand-off; all outputs registered, one-edge latency; pw_valid held until pw_ack.
// Define KEYPAD_MASK_EN to show captured digits as dashes on the displays.
module parking_keypad_entry
   import parking_pkg::*;
#(
   parameter  int TIMEOUT_CYCLES = 1000,
   localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                   clk,
   input  logic                   reset,
   parking_keypad_entry_if.master kp
);

`ifdef KEYPAD_MASK_EN
   localparam logic MASK_ON = 1'b1;
`else
   localparam logic MASK_ON = 1'b0;
`endif

   state_t           state, state_nxt;
   digit_t           d1, d1_nxt, d2, d2_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             tflag_nxt;
   logic             key_pulse;
   logic             tmo;
   logic [1:0]       dc_nxt;
   logic [6:0]       hex1_nxt, hex2_nxt;

   assign key_pulse = kp.key_strobe | kp.key_enter | kp.key_clear;

   // Any key pulse in the limit cycle keeps the entry alive.
   assign tmo = (state == ONE || state == TWO) && !key_pulse &&
                (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nxt = state;
      d1_nxt    = d1;
      d2_nxt    = d2;
      tflag_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (kp.key_clear) begin
               d1_nxt = '0;
               d2_nxt = '0;
            end else if (kp.key_strobe) begin
               d1_nxt    = kp.key_code;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (kp.key_clear) begin
               state_nxt = IDLE;
               d1_nxt    = '0;
               d2_nxt    = '0;
            end else if (kp.key_strobe && !kp.key_enter) begin
               d2_nxt    = kp.key_code;
               state_nxt = TWO;
            end else if (tmo) begin
               state_nxt = IDLE;
               d1_nxt    = '0;
               d2_nxt    = '0;
               tflag_nxt = 1'b1;
            end
         end
         TWO: begin
            if (kp.key_clear) begin
               state_nxt = IDLE;
               d1_nxt    = '0;
               d2_nxt    = '0;
            end else if (kp.key_enter) begin
               state_nxt = SEND;
            end else if (tmo) begin
               state_nxt = IDLE;
               d1_nxt    = '0;
               d2_nxt    = '0;
               tflag_nxt = 1'b1;
            end
         end
         default: begin
            if (kp.pw_ack) begin
               state_nxt = IDLE;
               d1_nxt    = '0;
               d2_nxt    = '0;
            end
         end
      endcase

      cnt_nxt = cnt;
      if (key_pulse || state_nxt != state) begin
         cnt_nxt = '0;
      end else if (state == ONE || state == TWO) begin
         cnt_nxt = cnt + CNT_W'(1);
      end

      case (state_nxt)
         IDLE:    dc_nxt = 2'd0;
         ONE:     dc_nxt = 2'd1;
         default: dc_nxt = 2'd2;
      endcase
   end

   seg7_digit_decoder u_dec_1 (
      .digit   (d1_nxt),
      .present (state_nxt != IDLE),
      .mask    (MASK_ON),
      .seg     (hex1_nxt)
   );

   seg7_digit_decoder u_dec_2 (
      .digit   (d2_nxt),
      .present (state_nxt == TWO || state_nxt == SEND),
      .mask    (MASK_ON),
      .seg     (hex2_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         d1              <= '0;
         d2              <= '0;
         cnt             <= '0;
         kp.pw_valid     <= 1'b0;
         kp.password_1   <= '0;
         kp.password_2   <= '0;
         kp.digit_count  <= 2'd0;
         kp.timeout_flag <= 1'b0;
         kp.HEX_1        <= SEG_BLANK;
         kp.HEX_2        <= SEG_BLANK;
      end else begin
         state           <= state_nxt;
         d1              <= d1_nxt;
         d2              <= d2_nxt;
         cnt             <= cnt_nxt;
         kp.pw_valid     <= (state_nxt == SEND);
         kp.password_1   <= (state_nxt == SEND) ? d1_nxt : '0;
         kp.password_2   <= (state_nxt == SEND) ? d2_nxt : '0;
         kp.digit_count  <= dc_nxt;
         kp.timeout_flag <= tflag_nxt;
         kp.HEX_1        <= hex1_nxt;
         kp.HEX_2        <= hex2_nxt;
      end
   end

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Directed bench for parking_keypad_entry with the default 1000-cycle timeout.
module tb_parking_keypad_entry;

   localparam logic [6:0] E_BLANK = 7'b1111111;
`ifdef KEYPAD_MASK_EN
   localparam logic [6:0] E_0 = 7'b0111111;
   localparam logic [6:0] E_1 = 7'b0111111;
   localparam logic [6:0] E_2 = 7'b0111111;
   localparam logic [6:0] E_3 = 7'b0111111;
`else
   localparam logic [6:0] E_0 = 7'b1000000;
   localparam logic [6:0] E_1 = 7'b1111001;
   localparam logic [6:0] E_2 = 7'b0100100;
   localparam logic [6:0] E_3 = 7'b0110000;
`endif

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   parking_keypad_entry_if kp_if ();

   parking_keypad_entry dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_all(input string tag, input logic vld, input logic [1:0] p1,
                            input logic [1:0] p2, input logic [1:0] dc, input logic tf,
                            input logic [6:0] h1, input logic [6:0] h2);
      total++;
      assert (kp_if.pw_valid === vld) else begin
         bad++; $error("FAIL %s pw_valid got=%b want=%b", tag, kp_if.pw_valid, vld);
      end
      total++;
      assert (kp_if.password_1 === p1) else begin
         bad++; $error("FAIL %s password_1 got=%0d want=%0d", tag, kp_if.password_1, p1);
      end
      total++;
      assert (kp_if.password_2 === p2) else begin
         bad++; $error("FAIL %s password_2 got=%0d want=%0d", tag, kp_if.password_2, p2);
      end
      total++;
      assert (kp_if.digit_count === dc) else begin
         bad++; $error("FAIL %s digit_count got=%0d want=%0d", tag, kp_if.digit_count, dc);
      end
      total++;
      assert (kp_if.timeout_flag === tf) else begin
         bad++; $error("FAIL %s timeout_flag got=%b want=%b", tag, kp_if.timeout_flag, tf);
      end
      total++;
      assert (kp_if.HEX_1 === h1) else begin
         bad++; $error("FAIL %s HEX_1 got=%b want=%b", tag, kp_if.HEX_1, h1);
      end
      total++;
      assert (kp_if.HEX_2 === h2) else begin
         bad++; $error("FAIL %s HEX_2 got=%b want=%b", tag, kp_if.HEX_2, h2);
      end
   endtask

   // One-cycle key pulse driven at a falling edge; returns at the falling edge after it is sampled.
   task automatic drive(input logic s, input logic [1:0] c, input logic e, input logic cl);
      @(negedge clk);
      kp_if.key_strobe = s;
      kp_if.key_code   = c;
      kp_if.key_enter  = e;
      kp_if.key_clear  = cl;
      @(negedge clk);
      kp_if.key_strobe = 1'b0;
      kp_if.key_code   = 2'd0;
      kp_if.key_enter  = 1'b0;
      kp_if.key_clear  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset            = 1'b1;
      kp_if.key_strobe = 1'b0;
      kp_if.key_code   = 2'd0;
      kp_if.key_enter  = 1'b0;
      kp_if.key_clear  = 1'b0;
      kp_if.pw_ack     = 1'b0;
      idle(2);
      check_all("reset", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, E_BLANK, E_BLANK);
      reset = 1'b0;
      idle(1);

      // Full entry and hand-off
      drive(1'b1, 2'd1, 1'b0, 1'b0);
      check_all("digit1", 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, E_1, E_BLANK);
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      check_all("digit2", 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, E_1, E_2);
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      check_all("strobe_in_two", 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, E_1, E_2);
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      check_all("enter", 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, E_1, E_2);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check_all("send_hold", 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, E_1, E_2);
      end
      drive(1'b1, 2'd3, 1'b0, 1'b1);
      check_all("clear_in_send", 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, E_1, E_2);
      kp_if.pw_ack = 1'b1;
      idle(1);
      kp_if.pw_ack = 1'b0;
      check_all("ack", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, E_BLANK, E_BLANK);

      // Timeout after one digit: flag in exactly the cycle after edge K+1000
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      idle(999);
      check_all("pre_timeout", 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, E_3, E_BLANK);
      idle(1);
      check_all("timeout", 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, E_BLANK, E_BLANK);
      idle(1);
      check_all("post_timeout", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, E_BLANK, E_BLANK);

      // Key pulse in the limit cycle cancels the timeout
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      idle(998);
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      check_all("key_beats_timeout", 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, E_3, E_BLANK);
      idle(5);
      check_all("counter_restarted", 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, E_3, E_BLANK);

      // Clear beats enter
      drive(1'b0, 2'd0, 1'b1, 1'b1);
      check_all("clear_over_enter", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, E_BLANK, E_BLANK);

      // Enter with a single digit is ignored; clear beats strobe
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      check_all("enter_in_one", 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, E_2, E_BLANK);
      drive(1'b1, 2'd1, 1'b0, 1'b1);
      check_all("clear_over_strobe", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, E_BLANK, E_BLANK);

      // Ack outside SEND has no effect
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      kp_if.pw_ack = 1'b1;
      idle(1);
      kp_if.pw_ack = 1'b0;
      check_all("ack_in_idle", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, E_BLANK, E_BLANK);

      // Asynchronous reset in SEND
      drive(1'b1, 2'd0, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      check_all("enter_03", 1'b1, 2'd0, 2'd3, 2'd2, 1'b0, E_0, E_3);
      #2 reset = 1'b1;
      #1;
      check_all("async_reset", 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, E_BLANK, E_BLANK);
      #1 reset = 1'b0;
      idle(2);
      drive(1'b1, 2'd1, 1'b0, 1'b0);
      check_all("after_reset", 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, E_1, E_BLANK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parking_keypad_entry.md
# parking_keypad_entry

Driver-side keypad front end for the parking gate. It collects two 2-bit password digits from a debounced keypad and shows them on two 7-segment displays. On ENTER it presents the pair on `password_1`/`password_2` to the gate controller with a valid/ack handshake. It sits between the keypad scanner and the gate's password inputs and is the initiator of the password transfer the gate consumes.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles after which a partial entry is abandoned; legal range ≥ 2.
- `CNT_W`, default `$clog2(TIMEOUT_CYCLES)`: width of the timeout counter; derived, never overridden.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `key_strobe`  in  1  one-cycle pulse; `key_code` is valid this cycle.
- `key_code`  in  2  digit value 0..3.
- `key_enter`  in  1  one-cycle pulse, submit request.
- `key_clear`  in  1  one-cycle pulse, discard entry.
- `pw_ack`  in  1  gate has sampled the password.
- `pw_valid`  out  1  password pair valid; held until acked.
- `password_1`  out  2  first digit; 0 when `pw_valid` is low.
- `password_2`  out  2  second digit; 0 when `pw_valid` is low.
- `digit_count`  out  2  digits captured so far (0..2).
- `timeout_flag`  out  1  one-cycle pulse when an entry is abandoned by timeout.
- `HEX_1`  out  7  display for digit 1, active-low, bit order {g,f,e,d,c,b,a}.
- `HEX_2`  out  7  display for digit 2, same encoding as `HEX_1`.

## Operation
- States: IDLE, ONE, TWO, SEND.
- IDLE: `key_strobe` captures `key_code` into d1 and moves to ONE.
- ONE: `key_strobe` captures `key_code` into d2 and moves to TWO.
- TWO: further `key_strobe` pulses are ignored.
- TWO: `key_enter` moves to SEND and drives `pw_valid`=1, `password_1`=d1, `password_2`=d2.
- `key_enter` in IDLE or ONE is ignored.
- SEND: outputs hold stable until `pw_ack`=1 is sampled. The block then returns to IDLE and clears d1, d2 and `digit_count`.
- SEND: all key inputs, including clear, are ignored. SEND has no timeout.
- `key_clear` in IDLE, ONE or TWO returns to IDLE and clears d1 and d2. No `timeout_flag` pulse.
- Same-cycle priority: clear > enter > strobe.
- `pw_ack` outside SEND is ignored.
- Timeout counter:
  - resets to 0 on any key pulse and on every state change;
  - increments every cycle in ONE or TWO;
  - when it reaches `TIMEOUT_CYCLES-1`, the next edge goes to IDLE, clears d1/d2 and pulses `timeout_flag`.
  - A key pulse in that same cycle wins: the counter is reset and no timeout occurs.
- Displays:
  - A digit not yet captured shows blank 7'b1111111.
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000.
- Reset values: state IDLE, `pw_valid` 0, passwords 0, `digit_count` 0, `timeout_flag` 0, both HEX 7'b1111111, counter 0.

## Timing
- All outputs are registered.
- Key pulse sampled at edge N: `digit_count` and HEX update after edge N.
- `key_enter` sampled at edge N in TWO: `pw_valid` is high from edge N; minimum valid time is one cycle.
- `pw_ack` sampled at edge M: `pw_valid` and passwords are 0 after edge M. A new digit is accepted no earlier than edge M+1.
- Timeout: the last key at edge K gives `timeout_flag` high for exactly the cycle after edge K+`TIMEOUT_CYCLES`.
- `reset` asserted mid-SEND drops `pw_valid` immediately (asynchronous), with no handshake completion.

## Configuration
- `KEYPAD_MASK_EN` defined: a captured digit displays dash 7'b0111111 instead of its value; blanks are unchanged.
- `KEYPAD_MASK_EN` undefined: captured digits display their values.
- `password_*` outputs are identical in both builds.

## Structure
- Package `parking_pkg` holds:
  - the state enum (IDLE/ONE/TWO/SEND);
  - the segment constants SEG_0..SEG_3, SEG_BLANK, SEG_DASH;
  - the 2-bit digit type.
- Sub-module `seg7_digit_decoder`: 2-bit digit + present flag + mask → 7-bit active-low pattern, purely combinational. It is instantiated twice, and its outputs are registered in the parent.

## Test plan
- Reset → `pw_valid`=0, passwords 00/00, HEX_1 = HEX_2 = 7'b1111111, `digit_count`=0.
- Strobe 1, strobe 2, enter, `pw_ack` held low for 5 cycles → `pw_valid`=1 with 01/10 stable throughout, HEX_1 = 7'b1111001, HEX_2 = 7'b0100100.
- Raise `pw_ack` → `pw_valid`=0 and passwords 00 next cycle, `digit_count`=0, both HEX blank.
- Strobe 3, then no keys for 1000 cycles → `timeout_flag` high for one cycle, state IDLE, HEX_1 blank.
- Strobe 3, then clear and enter in the same cycle → IDLE, no `pw_valid`. Enter after a single digit → ignored, `digit_count` stays 1.
- Enter in TWO, then `reset` pulse before `pw_ack` → `pw_valid` falls without a clock edge; with `KEYPAD_MASK_EN`, captured digits show 7'b0111111.
